highscore_table_updater: RTL and testbench
==========================================

HIGHSCORE_TABLE_UPDATER -- requirements
Module: highscore_table_updater

Interface
REQ-001 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port submit_valid, input, 1: a new game result is offered.
REQ-004 SHALL have port submit_ready, output, 1: block can accept a result; high only in IDLE.
REQ-005 SHALL have port submit_mode, input, 1: 1 = endless (higher score wins), 0 = classic (lower time wins).
REQ-006 SHALL have port submit_name, input, 18: three 6-bit glyph codes, char2 in [17:12], char1 in [11:6], char0 in [5:0].
REQ-007 SHALL have port submit_score, input, 16: 4-digit BCD, dig3 in [15:12] down to dig0 in [3:0]; classic value is mm:ss.
REQ-008 SHALL have port display_mode, input, 1: selects the table driven onto name1..3/score1..3 (same encoding as submit_mode).
REQ-009 SHALL have ports name1, name2, name3, output, 32 each: rank 1-3 names, [17:0] valid, [31:18] = 0.
REQ-010 SHALL have ports score1, score2, score3, output, 32 each: rank 1-3 BCD scores, [15:0] valid, [31:16] = 0.
REQ-011 SHALL have port insert_rank, output, 2: rank of last processed result, 0 = not placed, 1-3 = slot written; held until next accept.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when processing of an accepted result completes.

Function
REQ-013 SHALL hold two 3-entry tables (endless, classic), each entry 18-bit name + 16-bit score, rank 1 best.
REQ-014 SHALL drive name1..3/score1..3 combinationally from registered table selected by display_mode; a table write is visible the cycle after the write edge.
REQ-015 SHALL use FSM states IDLE, CMP1, CMP2, CMP3, WRITE, DONE.
REQ-016 IDLE: submit_ready=1; on edge with submit_valid=1 capture mode/name/score, set insert_rank=0, go CMP1; else stay.
REQ-017 Inputs SHALL be ignored outside IDLE; submit_ready=0 in all other states.
REQ-018 Captured score with any digit > 9 SHALL be invalid: CMP1 goes directly to DONE, insert_rank=0, no table change.
REQ-019 CMPk (k=1..3): compare captured score with entry k of captured-mode table as 16-bit unsigned; win = strictly greater (endless) or strictly less (classic); win -> latch insert_rank=k, go WRITE; loss -> CMP(k+1), or DONE from CMP3 with insert_rank=0.
REQ-020 Ties SHALL lose (existing entry keeps its rank; new result placed below).
REQ-021 WRITE (one cycle): entries below rank k shift down one slot, old entry 3 discarded, captured name/score written to slot k; other table untouched; go DONE.
REQ-022 DONE: done=1 for exactly this cycle, go IDLE.
REQ-023 Latency from accept edge to done-high cycle: k+1 cycles when placed at rank k, 3 cycles when rejected at CMP3, 1 cycle when BCD-invalid.
REQ-024 display_mode changes SHALL take effect immediately and SHALL NOT disturb processing.

Reset
REQ-025 On reset: state IDLE, submit_ready=1, done=0, insert_rank=0.
REQ-026 On reset: all names = 18'h0; endless scores = 16'h0000; classic scores = 16'h9959.
REQ-027 Reset in any state SHALL abort processing with no partial table write; reset has priority over submit_valid.

Verification
REQ-028 After reset, endless submit name 18'h0A2C3, score 16'h0150 -> done 2 cycles after accept, insert_rank=1, display_mode=1 shows name1=32'h0000A2C3, score1=32'h00000150, score2/3=0.
REQ-029 Endless table scores {0500,0300,0100}; submit 0300 -> CMP1 lose, CMP2 tie lose, CMP3 win; insert_rank=3, table {0500,0300,0300}; done 4 cycles after accept.
REQ-030 Classic table {0130,0245,0400}; submit 0200 -> insert_rank=2, table {0130,0200,0245}, old 0400 dropped; endless table unchanged.
REQ-031 Submit score 16'h01A0 -> done 1 cycle after accept, insert_rank=0, no table change; also classic 9959 into default table -> insert_rank=0.
REQ-032 Assert reset while in CMP2 -> next cycle IDLE, submit_ready=1, tables at REQ-026 defaults; submit_valid held during busy states is not accepted until IDLE.

Source files
------------

// File: rtl/highscore_table_updater.sv
// rtl/highscore_table_updater.sv - three-entry endless/classic highscore tables with compare-and-insert FSM
//
// Purpose: accepts one game result at a time, compares it against the table of
// its mode (endless: higher BCD score wins, classic: lower mm:ss wins), and
// inserts it at the first rank it beats, shifting lower entries down.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   submit_valid / submit_ready   result handshake, ready only while idle
//   submit_mode                   1 = endless, 0 = classic
//   submit_name [17:0]            three 6-bit glyphs, char2 in [17:12]
//   submit_score [15:0]           4-digit BCD score or mm:ss time
//   display_mode                  selects the table shown on name1..3/score1..3
//   name1..name3 [31:0]           rank 1-3 names, zero-extended
//   score1..score3 [31:0]         rank 1-3 scores, zero-extended
//   insert_rank [1:0]             rank written by the last result, 0 = not placed
//   done                          one-cycle pulse when a result finishes
module highscore_table_updater (
    input  logic        clock,
    input  logic        reset,
    input  logic        submit_valid,
    output logic        submit_ready,
    input  logic        submit_mode,
    input  logic [17:0] submit_name,
    input  logic [15:0] submit_score,
    input  logic        display_mode,
    output logic [31:0] name1,
    output logic [31:0] name2,
    output logic [31:0] name3,
    output logic [31:0] score1,
    output logic [31:0] score2,
    output logic [31:0] score3,
    output logic [1:0]  insert_rank,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMP1  = 3'd1,
        CMP2  = 3'd2,
        CMP3  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [15:0] CLASSIC_EMPTY = 16'h9959;

    state_t state;

    // Entry 0 is rank 1.
    logic [2:0][17:0] end_name;
    logic [2:0][15:0] end_score;
    logic [2:0][17:0] cls_name;
    logic [2:0][15:0] cls_score;

    logic        cap_mode;
    logic [17:0] cap_name;
    logic [15:0] cap_score;

    logic [15:0] entry_score;
    logic        win;
    logic        bcd_ok;

    // Insert v at rank k (1..3); entries at and below k move down one slot,
    // the old rank-3 entry falls off.
    function automatic logic [2:0][17:0] ins_name(input logic [2:0][17:0] t,
                                                  input logic [1:0] k,
                                                  input logic [17:0] v);
        logic [2:0][17:0] r;
        r = t;
        case (k)
            2'd1:    r = {t[1], t[0], v};
            2'd2:    r = {t[1], v, t[0]};
            2'd3:    r = {v, t[1], t[0]};
            default: r = t;
        endcase
        return r;
    endfunction

    function automatic logic [2:0][15:0] ins_score(input logic [2:0][15:0] t,
                                                   input logic [1:0] k,
                                                   input logic [15:0] v);
        logic [2:0][15:0] r;
        r = t;
        case (k)
            2'd1:    r = {t[1], t[0], v};
            2'd2:    r = {t[1], v, t[0]};
            2'd3:    r = {v, t[1], t[0]};
            default: r = t;
        endcase
        return r;
    endfunction

    // Entry under comparison follows the CMP state, from the captured mode's table.
    always_comb begin
        entry_score = cap_mode ? end_score[0] : cls_score[0];
        case (state)
            CMP2:    entry_score = cap_mode ? end_score[1] : cls_score[1];
            CMP3:    entry_score = cap_mode ? end_score[2] : cls_score[2];
            default: entry_score = cap_mode ? end_score[0] : cls_score[0];
        endcase
    end

    // Ties lose in both modes so an existing entry keeps its rank.
    assign win = cap_mode ? (cap_score > entry_score) : (cap_score < entry_score);

    assign bcd_ok = (cap_score[15:12] <= 4'd9) && (cap_score[11:8] <= 4'd9) &&
                    (cap_score[7:4]   <= 4'd9) && (cap_score[3:0]  <= 4'd9);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            submit_ready <= 1'b1;
            done         <= 1'b0;
            insert_rank  <= 2'd0;
            cap_mode     <= 1'b0;
            cap_name     <= 18'h0;
            cap_score    <= 16'h0;
            end_name     <= '0;
            cls_name     <= '0;
            end_score    <= '0;
            cls_score    <= {CLASSIC_EMPTY, CLASSIC_EMPTY, CLASSIC_EMPTY};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (submit_valid) begin
                        cap_mode     <= submit_mode;
                        cap_name     <= submit_name;
                        cap_score    <= submit_score;
                        insert_rank  <= 2'd0;
                        submit_ready <= 1'b0;
                        state        <= CMP1;
                    end
                end
                CMP1: begin
                    if (!bcd_ok) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (win) begin
                        insert_rank <= 2'd1;
                        state       <= WRITE;
                    end else begin
                        state <= CMP2;
                    end
                end
                CMP2: begin
                    if (win) begin
                        insert_rank <= 2'd2;
                        state       <= WRITE;
                    end else begin
                        state <= CMP3;
                    end
                end
                CMP3: begin
                    if (win) begin
                        insert_rank <= 2'd3;
                        state       <= WRITE;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                WRITE: begin
                    if (cap_mode) begin
                        end_name  <= ins_name(end_name, insert_rank, cap_name);
                        end_score <= ins_score(end_score, insert_rank, cap_score);
                    end else begin
                        cls_name  <= ins_name(cls_name, insert_rank, cap_name);
                        cls_score <= ins_score(cls_score, insert_rank, cap_score);
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    submit_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    submit_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign name1  = {14'h0, display_mode ? end_name[0]  : cls_name[0]};
    assign name2  = {14'h0, display_mode ? end_name[1]  : cls_name[1]};
    assign name3  = {14'h0, display_mode ? end_name[2]  : cls_name[2]};
    assign score1 = {16'h0, display_mode ? end_score[0] : cls_score[0]};
    assign score2 = {16'h0, display_mode ? end_score[1] : cls_score[1]};
    assign score3 = {16'h0, display_mode ? end_score[2] : cls_score[2]};

endmodule

// File: tb/tb_highscore_table_updater.sv
// tb/tb_highscore_table_updater.sv - self-checking bench for highscore_table_updater
module tb_highscore_table_updater;

    logic        clock = 1'b0;
    logic        reset;
    logic        submit_valid;
    logic        submit_ready;
    logic        submit_mode;
    logic [17:0] submit_name;
    logic [15:0] submit_score;
    logic        display_mode;
    logic [31:0] name1, name2, name3;
    logic [31:0] score1, score2, score3;
    logic [1:0]  insert_rank;
    logic        done;

    highscore_table_updater dut (
        .clock        (clock),
        .reset        (reset),
        .submit_valid (submit_valid),
        .submit_ready (submit_ready),
        .submit_mode  (submit_mode),
        .submit_name  (submit_name),
        .submit_score (submit_score),
        .display_mode (display_mode),
        .name1        (name1),
        .name2        (name2),
        .name3        (name3),
        .score1       (score1),
        .score2       (score2),
        .score3       (score3),
        .insert_rank  (insert_rank),
        .done         (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        mode;
        logic [17:0] name;
        logic [15:0] score;
        int          rank;
        int          lat;
    } vec_t;

    typedef struct {
        int rank;
        int lat;
    } exp_t;

    vec_t vecs[15];
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // Reference tables indexed [mode][rank-1]
    logic [17:0] m_name[2][3];
    logic [15:0] m_score[2][3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_name[0][i] = 18'h0; m_score[0][i] = 16'h9959;
            m_name[1][i] = 18'h0; m_score[1][i] = 16'h0000;
        end
    endtask

    task automatic model_insert(input logic m, input int k, input logic [17:0] nm, input logic [15:0] sc);
        int md;
        md = m ? 1 : 0;
        if (k >= 1 && k <= 3) begin
            for (int i = 2; i >= k; i--) begin
                m_name[md][i]  = m_name[md][i-1];
                m_score[md][i] = m_score[md][i-1];
            end
            m_name[md][k-1]  = nm;
            m_score[md][k-1] = sc;
        end
    endtask

    task automatic check_tables(input string tag);
        logic keep;
        keep = display_mode;
        for (int md = 0; md < 2; md++) begin
            display_mode = (md == 1);
            #1;
            chk({tag, "_name1"},  name1,  {14'h0, m_name[md][0]});
            chk({tag, "_name2"},  name2,  {14'h0, m_name[md][1]});
            chk({tag, "_name3"},  name3,  {14'h0, m_name[md][2]});
            chk({tag, "_score1"}, score1, {16'h0, m_score[md][0]});
            chk({tag, "_score2"}, score2, {16'h0, m_score[md][1]});
            chk({tag, "_score3"}, score3, {16'h0, m_score[md][2]});
        end
        display_mode = keep;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        submit_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_done(output int n, output bit got);
        n = 0;
        got = 0;
        while (!got && n < 12) begin
            @(posedge clock); #1;
            n++;
            if (done) got = 1;
        end
    endtask

    task automatic run_txn(input string tag, input logic m, input logic [17:0] nm,
                           input logic [15:0] sc, input int rank, input int lat);
        int   n;
        bit   got;
        exp_t e;
        sb.push_back('{rank: rank, lat: lat});
        chk({tag, "_ready_idle"}, {31'h0, submit_ready}, 32'd1);
        submit_mode  = m;
        submit_name  = nm;
        submit_score = sc;
        submit_valid = 1'b1;
        @(posedge clock); #1;
        submit_valid = 1'b0;
        submit_score = 16'h1234;
        submit_mode  = ~m;
        chk({tag, "_ready_busy"}, {31'h0, submit_ready}, 32'd0);
        wait_done(n, got);
        e = sb.pop_front();
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no done within %0d cycles", tag, n);
        end else begin
            chk({tag, "_latency"}, n, e.lat);
            chk({tag, "_rank"}, {30'h0, insert_rank}, e.rank);
        end
        @(posedge clock); #1;
        chk({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
        chk({tag, "_rank_held"}, {30'h0, insert_rank}, e.rank);
        model_insert(m, e.rank, nm, sc);
        check_tables(tag);
    endtask

    initial begin
        int n;
        bit got;

        vecs[0]  = '{1'b1, 18'h00001, 16'h0100, 1, 2};
        vecs[1]  = '{1'b1, 18'h00002, 16'h0300, 1, 2};
        vecs[2]  = '{1'b1, 18'h00003, 16'h0500, 1, 2};
        vecs[3]  = '{1'b1, 18'h00004, 16'h0300, 3, 4};
        vecs[4]  = '{1'b1, 18'h00005, 16'h0300, 0, 3};
        vecs[5]  = '{1'b1, 18'h00006, 16'h01A0, 0, 1};
        vecs[6]  = '{1'b0, 18'h00007, 16'h9959, 0, 3};
        vecs[7]  = '{1'b0, 18'h00008, 16'h0400, 1, 2};
        vecs[8]  = '{1'b0, 18'h00009, 16'h0130, 1, 2};
        vecs[9]  = '{1'b0, 18'h0000A, 16'h0245, 2, 3};
        vecs[10] = '{1'b0, 18'h0000B, 16'h0200, 2, 3};
        vecs[11] = '{1'b0, 18'h0000C, 16'h9999, 0, 3};
        vecs[12] = '{1'b0, 18'h0000D, 16'h0000, 1, 2};
        vecs[13] = '{1'b1, 18'h3F0E0, 16'h9999, 1, 2};
        vecs[14] = '{1'b0, 18'h0000F, 16'h99F9, 0, 1};

        submit_mode  = 1'b0;
        submit_name  = 18'h0;
        submit_score = 16'h0;
        display_mode = 1'b1;
        do_reset();

        // Reset state
        chk("rst_ready", {31'h0, submit_ready}, 32'd1);
        chk("rst_done",  {31'h0, done}, 32'd0);
        chk("rst_rank",  {30'h0, insert_rank}, 32'd0);
        check_tables("rst");

        // First endless result lands at rank 1
        run_txn("first", 1'b1, 18'h0A2C3, 16'h0150, 1, 2);
        display_mode = 1'b1; #1;
        chk("first_name1_abs",  name1,  32'h0000A2C3);
        chk("first_score1_abs", score1, 32'h00000150);
        chk("first_score2_abs", score2, 32'h00000000);
        chk("first_score3_abs", score3, 32'h00000000);

        // Reset while in CMP2 aborts without writing
        run_txn("pre_abort", 1'b1, 18'h00100, 16'h0500, 1, 2);
        submit_mode = 1'b1; submit_name = 18'h00200; submit_score = 16'h0100;
        submit_valid = 1'b1;
        @(posedge clock); #1;
        submit_valid = 1'b0;
        @(posedge clock); #1;
        chk("abort_busy", {31'h0, submit_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        chk("abort_ready", {31'h0, submit_ready}, 32'd1);
        chk("abort_done",  {31'h0, done}, 32'd0);
        chk("abort_rank",  {30'h0, insert_rank}, 32'd0);
        check_tables("abort");

        // submit_valid held high: inputs changed mid-flight must be ignored
        submit_mode = 1'b1; submit_name = 18'h00011; submit_score = 16'h0200;
        submit_valid = 1'b1;
        @(posedge clock); #1;
        submit_name = 18'h00022; submit_score = 16'h0050;
        wait_done(n, got);
        chk("held1_got", {31'h0, got}, 32'd1);
        chk("held1_lat", n, 32'd2);
        chk("held1_rank", {30'h0, insert_rank}, 32'd1);
        model_insert(1'b1, 1, 18'h00011, 16'h0200);
        wait_done(n, got);
        submit_valid = 1'b0;
        chk("held2_got", {31'h0, got}, 32'd1);
        chk("held2_lat", n, 32'd5);
        chk("held2_rank", {30'h0, insert_rank}, 32'd2);
        model_insert(1'b1, 2, 18'h00022, 16'h0050);
        @(posedge clock); #1;
        check_tables("held");

        // Table-driven vectors from a fresh reset
        do_reset();
        for (int i = 0; i < 15; i++) begin
            display_mode = i[0];
            run_txn($sformatf("vec%0d", i), vecs[i].mode, vecs[i].name,
                    vecs[i].score, vecs[i].rank, vecs[i].lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
